// File: rtl/cmul_seq_if.sv
// cmul_seq_if: bundles the three buses of the complex multiplier sequencer.
//   Operand input  : in_valid/in_ready handshake with xr, xi, wr, wi (signed DW).
//   Result output  : out_valid/out_ready handshake with yr, yi (signed PW+1).
//   Multiplier bus : mul_en, mul_a, mul_b toward the shared multiplier,
//                    mul_p (signed PW) back from it, combinational.
// Modports:
//   slave  - the sequencer itself.
//   master - the surroundings: upstream fetch, downstream add/sub, multiplier.
interface cmul_seq_if #(
  parameter int DW = 8,
  parameter int PW = 2 * DW
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] xr;
  logic signed [DW-1:0] xi;
  logic signed [DW-1:0] wr;
  logic signed [DW-1:0] wi;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [PW:0]   yr;
  logic signed [PW:0]   yi;

  logic                 mul_en;
  logic signed [DW-1:0] mul_a;
  logic signed [DW-1:0] mul_b;
  logic signed [PW-1:0] mul_p;

  modport slave (
    input  in_valid, xr, xi, wr, wi, out_ready, mul_p,
    output in_ready, out_valid, yr, yi, mul_en, mul_a, mul_b
  );

  modport master (
    output in_valid, xr, xi, wr, wi, out_ready, mul_p,
    input  in_ready, out_valid, yr, yi, mul_en, mul_a, mul_b
  );
endinterface

// File: rtl/cmul_seq.sv
// cmul_seq: time-multiplexed complex multiplier sequencer.
// Computes y = x * w (yr = xr*wr - xi*wi, yi = xr*wi + xi*wr) exactly in PW+1
// bits by walking one shared signed DW x DW multiplier through four real
// products in four cycles, then presenting the result on a valid/ready port.
// Ports:
//   clk - single rising-edge clock.
//   rst - synchronous active-high reset; aborts any operation in flight.
//   bus - cmul_seq_if slave modport (operand in, result out, multiplier bus).
module cmul_seq #(
  parameter int DW = 8,
  parameter int PW = 2 * DW
) (
  input  logic        clk,
  input  logic        rst,
  cmul_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL0 = 3'd1,
    S_MUL1 = 3'd2,
    S_MUL2 = 3'd3,
    S_MUL3 = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic signed [DW-1:0] xr_q, xr_d;
  logic signed [DW-1:0] xi_q, xi_d;
  logic signed [DW-1:0] wr_q, wr_d;
  logic signed [DW-1:0] wi_q, wi_d;
  logic signed [DW-1:0] mul_a_q, mul_a_d;
  logic signed [DW-1:0] mul_b_q, mul_b_d;
  logic signed [PW:0]   acc_r_q, acc_r_d;
  logic signed [PW:0]   acc_i_q, acc_i_d;
  logic                 out_valid_q, out_valid_d;
  logic                 mul_en_q, mul_en_d;

  logic                 in_ready_s;
  logic                 accept_s;
  logic signed [PW:0]   prod_ext_s;

  // Sign-extend the product by one bit so the sum/difference cannot wrap.
  assign prod_ext_s = {bus.mul_p[PW-1], bus.mul_p};

  // Ready when idle, or when the held result leaves this very cycle.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
    end else if (state_q == S_IDLE) begin
      in_ready_s = 1'b1;
    end else if ((state_q == S_DONE) && bus.out_ready) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign accept_s = bus.in_valid & in_ready_s;

  // Next-state, operand steering and accumulation.
  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    xi_d    = xi_q;
    wr_d    = wr_q;
    wi_d    = wi_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    acc_r_d = acc_r_q;
    acc_i_d = acc_i_q;

    // Each MULn state consumes the product of the operands set up in the
    // previous cycle and sets up the operands for the next product.
    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_MUL0: begin
        acc_r_d = prod_ext_s;                 // xr*wr
        mul_a_d = xi_q;
        mul_b_d = wi_q;
        state_d = S_MUL1;
      end
      S_MUL1: begin
        acc_r_d = acc_r_q - prod_ext_s;       // - xi*wi
        mul_a_d = xr_q;
        mul_b_d = wi_q;
        state_d = S_MUL2;
      end
      S_MUL2: begin
        acc_i_d = prod_ext_s;                 // xr*wi
        mul_a_d = xi_q;
        mul_b_d = wr_q;
        state_d = S_MUL3;
      end
      S_MUL3: begin
        acc_i_d = acc_i_q + prod_ext_s;       // + xi*wr
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An accept (from IDLE, or back-to-back from DONE) overrides the above:
    // latch the operand set and present the first product pair.
    if (accept_s) begin
      xr_d    = bus.xr;
      xi_d    = bus.xi;
      wr_d    = bus.wr;
      wi_d    = bus.wi;
      mul_a_d = bus.xr;
      mul_b_d = bus.wr;
      state_d = S_MUL0;
    end else begin
      xr_d    = xr_d;
      xi_d    = xi_d;
    end
  end

  // Registered status outputs derived from the state being entered.
  always_comb begin
    mul_en_d    = 1'b0;
    out_valid_d = 1'b0;
    case (state_d)
      S_MUL0, S_MUL1, S_MUL2, S_MUL3: begin
        mul_en_d    = 1'b1;
        out_valid_d = 1'b0;
      end
      S_DONE: begin
        mul_en_d    = 1'b0;
        out_valid_d = 1'b1;
      end
      default: begin
        mul_en_d    = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      xr_q        <= {DW{1'b0}};
      xi_q        <= {DW{1'b0}};
      wr_q        <= {DW{1'b0}};
      wi_q        <= {DW{1'b0}};
      mul_a_q     <= {DW{1'b0}};
      mul_b_q     <= {DW{1'b0}};
      acc_r_q     <= {(PW+1){1'b0}};
      acc_i_q     <= {(PW+1){1'b0}};
      out_valid_q <= 1'b0;
      mul_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      xr_q        <= xr_d;
      xi_q        <= xi_d;
      wr_q        <= wr_d;
      wi_q        <= wi_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      acc_r_q     <= acc_r_d;
      acc_i_q     <= acc_i_d;
      out_valid_q <= out_valid_d;
      mul_en_q    <= mul_en_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.yr        = acc_r_q;
  assign bus.yi        = acc_i_q;
  assign bus.mul_en    = mul_en_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;

endmodule

// File: tb/tb_cmul_seq.sv
// tb_cmul_seq: directed self-checking bench for cmul_seq.
// The bench plays upstream, downstream and the shared multiplier.
module tb_cmul_seq;
  localparam int DW = 8;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  cmul_seq_if #(.DW(DW), .PW(PW)) bus ();

  cmul_seq #(.DW(DW), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Combinational signed multiplier model.
  assign bus.mul_p = bus.mul_a * bus.mul_b;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int a, input int b, input int c, input int d);
    bus.xr = DW'(a);
    bus.xi = DW'(b);
    bus.wr = DW'(c);
    bus.wi = DW'(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_op(0, 0, 0, 0);
    step();
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    total++; if (bus.mul_en !== 1'b0) begin bad++; $display("FAIL rst_mul_en got %b want 0", bus.mul_en); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    total++; if ((bus.yr !== 17'sd0) || (bus.yi !== 17'sd0)) begin bad++; $display("FAIL rst_y got %0d/%0d want 0/0", bus.yr, bus.yi); end
    total++; if ((bus.mul_a !== 8'sd0) || (bus.mul_b !== 8'sd0)) begin bad++; $display("FAIL rst_mul_ab got %0d/%0d want 0/0", bus.mul_a, bus.mul_b); end
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    int ea[4] = '{3, 4, 3, 4};
    int eb[4] = '{5, 6, 6, 5};
    int en_cnt = 0;
    bus.out_ready = 1'b1;
    set_op(3, 4, 5, 6);
    bus.in_valid = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus.mul_en === 1'b1) en_cnt++;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid cycle %0d got %b want 0", c + 1, bus.out_valid); end
      total++; if (($signed(bus.mul_a) !== ea[c]) || ($signed(bus.mul_b) !== eb[c])) begin
        bad++; $display("FAIL single_mul_ops cycle %0d got %0d*%0d want %0d*%0d", c + 1, bus.mul_a, bus.mul_b, ea[c], eb[c]);
      end
      step();
    end
    total++; if (en_cnt !== 4) begin bad++; $display("FAIL single_mul_en_cycles got %0d want 4", en_cnt); end
    total++; if (bus.mul_en !== 1'b0) begin bad++; $display("FAIL single_mul_en_done got %b want 0", bus.mul_en); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
    total++; if ($signed(bus.yr) !== -9) begin bad++; $display("FAIL single_yr got %0d want -9", bus.yr); end
    total++; if ($signed(bus.yi) !== 38) begin bad++; $display("FAIL single_yi got %0d want 38", bus.yi); end
    step();
    total++; if ((bus.out_valid !== 1'b0) || (bus.in_ready !== 1'b1)) begin
      bad++; $display("FAIL single_after got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_extremes();
    int vx[2][4] = '{'{-128, -128, -128, -128}, '{127, -128, -128, 127}};
    int eyr[2] = '{0, 0};
    int eyi[2] = '{32768, 32513};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_op(vx[k][0], vx[k][1], vx[k][2], vx[k][3]);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      for (int c = 0; c < 4; c++) step();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ext%0d_valid got %b want 1", k, bus.out_valid); end
      total++; if ($signed(bus.yr) !== eyr[k]) begin bad++; $display("FAIL ext%0d_yr got %0d want %0d", k, bus.yr, eyr[k]); end
      total++; if ($signed(bus.yi) !== eyi[k]) begin bad++; $display("FAIL ext%0d_yi got %0d want %0d", k, bus.yi, eyi[k]); end
      step();
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    set_op(2, -3, 7, 1);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    for (int c = 0; c < 10; c++) begin
      set_op(99, 99, 99, 99);
      bus.in_valid = 1'b1;
      #1;
      total++; if ((bus.out_valid !== 1'b1) || ($signed(bus.yr) !== 17) || ($signed(bus.yi) !== -19)) begin
        bad++; $display("FAIL bp_hold cycle %0d got valid=%b y=%0d/%0d want 1 17/-19", c, bus.out_valid, bus.yr, bus.yi);
      end
      total++; if ((bus.in_ready !== 1'b0) || (bus.mul_en !== 1'b0)) begin
        bad++; $display("FAIL bp_ready_en cycle %0d got ready=%b en=%b want 0/0", c, bus.in_ready, bus.mul_en);
      end
      total++; if (($signed(bus.mul_a) !== -3) || ($signed(bus.mul_b) !== 7)) begin
        bad++; $display("FAIL bp_mul_hold cycle %0d got %0d*%0d want -3*7", c, bus.mul_a, bus.mul_b);
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready); end
    step();
    total++; if ((bus.out_valid !== 1'b0) || (bus.mul_en !== 1'b0) || (bus.in_ready !== 1'b1)) begin
      bad++; $display("FAIL bp_one_transfer got valid=%b en=%b ready=%b want 0/0/1", bus.out_valid, bus.mul_en, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int v[8][4] = '{'{1, 2, 3, 4}, '{-5, 7, 2, -3}, '{10, -10, 10, 10}, '{0, 1, 0, 1},
                    '{127, 127, 127, 127}, '{-1, -1, -1, 1}, '{50, -20, -3, 8}, '{-100, 33, 4, -2}};
    int eyr[8] = '{-5, 11, 200, -1, 0, 2, 10, -334};
    int eyi[8] = '{10, 29, 0, 0, 32258, 0, 460, 332};
    bus.out_ready = 1'b1;
    set_op(v[0][0], v[0][1], v[0][2], v[0][3]);
    bus.in_valid = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      if (k < 7) set_op(v[k+1][0], v[k+1][1], v[k+1][2], v[k+1][3]);
      else bus.in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b%0d_gap cycle %0d got valid=%b want 0", k, c + 1, bus.out_valid); end
        step();
      end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b%0d_valid got %b want 1", k, bus.out_valid); end
      total++; if (($signed(bus.yr) !== eyr[k]) || ($signed(bus.yi) !== eyi[k])) begin
        bad++; $display("FAIL b2b%0d_y got %0d/%0d want %0d/%0d", k, bus.yr, bus.yi, eyr[k], eyi[k]);
      end
      step();
    end
    total++; if ((bus.out_valid !== 1'b0) || (bus.mul_en !== 1'b0)) begin
      bad++; $display("FAIL b2b_tail got valid=%b en=%b want 0/0", bus.out_valid, bus.mul_en);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    set_op(9, 9, 9, 9);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    total++; if (bus.mul_en !== 1'b1) begin bad++; $display("FAIL rmid_busy got en=%b want 1", bus.mul_en); end
    rst = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready_in_rst got %b want 0", bus.in_ready); end
    step();
    total++; if ((bus.out_valid !== 1'b0) || (bus.mul_en !== 1'b0)) begin
      bad++; $display("FAIL rmid_flags got valid=%b en=%b want 0/0", bus.out_valid, bus.mul_en);
    end
    total++; if ((bus.yr !== 17'sd0) || (bus.yi !== 17'sd0) || (bus.mul_a !== 8'sd0) || (bus.mul_b !== 8'sd0)) begin
      bad++; $display("FAIL rmid_zero got y=%0d/%0d mul=%0d/%0d want all 0", bus.yr, bus.yi, bus.mul_a, bus.mul_b);
    end
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rmid_idle got ready=%b want 1", bus.in_ready); end
    for (int c = 0; c < 5; c++) begin
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_result cycle %0d got %b want 0", c, bus.out_valid); end
      step();
    end
    set_op(1, 1, 1, -1);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    total++; if ((bus.out_valid !== 1'b1) || ($signed(bus.yr) !== 2) || ($signed(bus.yi) !== 0)) begin
      bad++; $display("FAIL rmid_next_op got valid=%b y=%0d/%0d want 1 2/0", bus.out_valid, bus.yr, bus.yi);
    end
    step();
  endtask

  task automatic test_busy_ignore();
    bus.out_ready = 1'b1;
    set_op(3, -2, -4, 5);
    bus.in_valid = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      set_op(100, -100, 50, -50);
      bus.in_valid = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL busy_ready cycle %0d got %b want 0", c + 1, bus.in_ready); end
      step();
    end
    bus.in_valid = 1'b0;
    #1;
    total++; if ((bus.out_valid !== 1'b1) || ($signed(bus.yr) !== -2) || ($signed(bus.yi) !== 23)) begin
      bad++; $display("FAIL busy_result got valid=%b y=%0d/%0d want 1 -2/23", bus.out_valid, bus.yr, bus.yi);
    end
    step();
    total++; if ((bus.out_valid !== 1'b0) || (bus.mul_en !== 1'b0)) begin
      bad++; $display("FAIL busy_after got valid=%b en=%b want 0/0", bus.out_valid, bus.mul_en);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_busy_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
